addr_ctlr: RTL and testbench

Address controller of the SDIO CPLD, directly downstream of the state controller. It consumes the state controller's active-low address-latch strobe, its 3-bit bank select and its address-increment control. On each strobe it loads one byte from the data bus into the selected address/count register, or executes a start/abort command. During a transfer it steps the card address and remaining-transfer count on each completed data access, and flags completion.

---
 rtl/addr_ctlr.sv | 143 ++++++++++++++
 tb/tb_addr_ctlr.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/addr_ctlr.sv
// Address controller for the SDIO CPLD: byte-wise loading of the card address and
// transfer count from the state controller's strobes, then per-access stepping.
module addr_ctlr #(
  parameter int unsigned ADDR_W = 24,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              AC_PClk,
  input  logic              AC_Reset,
  input  logic [7:0]        AC_Data_Bus,
  input  logic              AC_StrbN,
  input  logic [2:0]        AC_BSel,
  input  logic              AC_Addr_Inc,
  input  logic              AC_Access,
  output logic [ADDR_W-1:0] AC_Addr,
  output logic [CNT_W-1:0]  AC_Count,
  output logic              AC_Busy,
  output logic              AC_Done
);

  localparam int unsigned HI_W = ADDR_W - 16;

  localparam logic [2:0] BANK_ADDR0 = 3'd0;
  localparam logic [2:0] BANK_ADDR1 = 3'd1;
  localparam logic [2:0] BANK_ADDR2 = 3'd2;
  localparam logic [2:0] BANK_CNT0  = 3'd3;
  localparam logic [2:0] BANK_CNT1  = 3'd4;
  localparam logic [2:0] BANK_START = 3'd5;
  localparam logic [2:0] BANK_ABORT = 3'd6;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  state_t            state_q;
  state_t            state_nxt;
  logic              busy_q;
  logic              done_q;
  logic              busy_d;
  logic              done_d;
  logic              strb_q;
  logic [ADDR_W-1:0] addr_q;
  logic [CNT_W-1:0]  count_q;

  logic load_c;
  logic wr_en_c;
  logic start_c;
  logic abort_c;
  logic step_c;
  logic last_c;

  // Strobe edge detect and command decode
  always_comb begin
    load_c  = strb_q & ~AC_StrbN;
    wr_en_c = load_c && (AC_BSel <= BANK_CNT1) && (state_q != ST_ACTIVE);
    start_c = load_c && (AC_BSel == BANK_START);
    abort_c = load_c && (AC_BSel == BANK_ABORT);
    step_c  = (state_q == ST_ACTIVE) && AC_Access && !abort_c && (count_q != '0);
    last_c  = step_c && (count_q == CNT_W'(1));
  end

  // State register plus registered status outputs
  always_ff @(posedge AC_PClk) begin
    if (AC_Reset) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_nxt;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_c) begin
          state_nxt = (count_q != '0) ? ST_ACTIVE : ST_DONE;
        end else if (abort_c) begin
          state_nxt = ST_IDLE;
        end
      end
      ST_ACTIVE: begin
        if (abort_c) begin
          state_nxt = ST_IDLE;
        end else if (last_c) begin
          state_nxt = ST_DONE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Status outputs follow the upcoming state so they land with it
  always_comb begin
    busy_d = 1'b0;
    done_d = 1'b0;
    case (state_nxt)
      ST_ACTIVE: busy_d = 1'b1;
      ST_DONE:   done_d = 1'b1;
      default: begin
        busy_d = 1'b0;
        done_d = 1'b0;
      end
    endcase
  end

  // Strobe history, address and count registers
  always_ff @(posedge AC_PClk) begin
    if (AC_Reset) begin
      strb_q  <= 1'b1;
      addr_q  <= '0;
      count_q <= '0;
    end else begin
      strb_q <= AC_StrbN;
      if (wr_en_c) begin
        case (AC_BSel)
          BANK_ADDR0: addr_q[7:0]        <= AC_Data_Bus;
          BANK_ADDR1: addr_q[15:8]       <= AC_Data_Bus;
          BANK_ADDR2: addr_q[ADDR_W-1:16] <= AC_Data_Bus[HI_W-1:0];
          BANK_CNT0:  count_q[7:0]       <= AC_Data_Bus;
          BANK_CNT1:  count_q[15:8]      <= AC_Data_Bus;
          default: ;
        endcase
      end else if (step_c) begin
        count_q <= count_q - CNT_W'(1);
        if (AC_Addr_Inc) begin
          addr_q <= addr_q + ADDR_W'(1);
        end
      end
    end
  end

  assign AC_Addr  = addr_q;
  assign AC_Count = count_q;
  assign AC_Busy  = busy_q;
  assign AC_Done  = done_q;

endmodule

// File: tb/tb_addr_ctlr.sv
// Directed bench for addr_ctlr: loads, single-load strobes, stepping, abort, reset.
module tb_addr_ctlr;

  localparam int unsigned ADDR_W = 24;
  localparam int unsigned CNT_W  = 16;

  logic              clk;
  logic              rst;
  logic [7:0]        data;
  logic              strbn;
  logic [2:0]        bsel;
  logic              addr_inc;
  logic              access;
  logic [ADDR_W-1:0] addr;
  logic [CNT_W-1:0]  count;
  logic              busy;
  logic              done;

  int total;
  int bad;

  addr_ctlr #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .AC_PClk     (clk),
    .AC_Reset    (rst),
    .AC_Data_Bus (data),
    .AC_StrbN    (strbn),
    .AC_BSel     (bsel),
    .AC_Addr_Inc (addr_inc),
    .AC_Access   (access),
    .AC_Addr     (addr),
    .AC_Count    (count),
    .AC_Busy     (busy),
    .AC_Done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One-cycle strobe; returns on the negedge after the load edge
  task automatic strobe(input logic [2:0] b, input logic [7:0] d);
    @(negedge clk);
    strbn = 1'b0;
    bsel  = b;
    data  = d;
    @(negedge clk);
    strbn = 1'b1;
  endtask

  task automatic pulse_access();
    @(negedge clk);
    access = 1'b1;
    @(negedge clk);
    access = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    total    = 0;
    bad      = 0;
    rst      = 1'b1;
    data     = 8'h00;
    strbn    = 1'b1;
    bsel     = 3'd7;
    addr_inc = 1'b1;
    access   = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_addr", 32'(addr), 32'h0);
    check("rst_count", 32'(count), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    rst = 1'b0;

    // 1: address bank loads
    strobe(3'd0, 8'h34);
    strobe(3'd1, 8'h12);
    strobe(3'd2, 8'hAB);
    check("t1_addr", 32'(addr), 32'h00AB1234);
    check("t1_busy", 32'(busy), 32'h0);
    check("t1_done", 32'(done), 32'h0);
    strobe(3'd7, 8'hEE);
    check("t1_bank7", 32'(addr), 32'h00AB1234);

    // 2: long strobe loads exactly once
    @(negedge clk);
    strbn = 1'b0; bsel = 3'd3; data = 8'h05;
    @(negedge clk);
    data = 8'h07;
    repeat (3) @(negedge clk);
    strbn = 1'b1;
    check("t2_count", 32'(count), 32'h0005);

    // 3: stepping with address wrap
    strobe(3'd0, 8'hFE);
    strobe(3'd1, 8'hFF);
    strobe(3'd2, 8'hFF);
    strobe(3'd3, 8'h03);
    strobe(3'd4, 8'h00);
    check("t3_addr_ld", 32'(addr), 32'h00FFFFFE);
    addr_inc = 1'b1;
    strobe(3'd5, 8'h00);
    check("t3_busy_start", 32'(busy), 32'h1);
    pulse_access();
    check("t3_addr1", 32'(addr), 32'h00FFFFFF);
    check("t3_cnt1", 32'(count), 32'h2);
    pulse_access();
    check("t3_addr2", 32'(addr), 32'h00000000);
    check("t3_cnt2", 32'(count), 32'h1);
    check("t3_done_mid", 32'(done), 32'h0);
    pulse_access();
    check("t3_addr3", 32'(addr), 32'h00000001);
    check("t3_cnt3", 32'(count), 32'h0);
    check("t3_done", 32'(done), 32'h1);
    check("t3_busy_end", 32'(busy), 32'h0);

    // 4: hold-address transfer, write ignored while active, abort beats access
    strobe(3'd3, 8'h04);
    check("t4_cnt_ld_done", 32'(count), 32'h4);
    check("t4_done_kept", 32'(done), 32'h1);
    addr_inc = 1'b0;
    strobe(3'd5, 8'h00);
    check("t4_busy", 32'(busy), 32'h1);
    check("t4_done_clr", 32'(done), 32'h0);
    pulse_access();
    pulse_access();
    strobe(3'd0, 8'h55);
    check("t4_addr_hold", 32'(addr), 32'h00000001);
    check("t4_cnt", 32'(count), 32'h2);
    @(negedge clk);
    strbn = 1'b0; bsel = 3'd6; access = 1'b1;
    @(negedge clk);
    strbn = 1'b1; access = 1'b0;
    check("t4_abort_cnt", 32'(count), 32'h2);
    check("t4_abort_busy", 32'(busy), 32'h0);
    check("t4_abort_done", 32'(done), 32'h0);

    // 5: zero-count start goes straight to DONE
    strobe(3'd3, 8'h00);
    strobe(3'd5, 8'h00);
    check("t5_done", 32'(done), 32'h1);
    check("t5_busy", 32'(busy), 32'h0);
    check("t5_addr", 32'(addr), 32'h00000001);
    pulse_access();
    check("t5_acc_cnt", 32'(count), 32'h0);
    check("t5_acc_addr", 32'(addr), 32'h00000001);
    strobe(3'd6, 8'h00);
    check("t5_abort_done", 32'(done), 32'h0);

    // 6: reset mid-transfer with accesses still arriving
    strobe(3'd3, 8'h10);
    addr_inc = 1'b1;
    strobe(3'd5, 8'h00);
    @(negedge clk);
    access = 1'b1;
    repeat (3) @(negedge clk);
    check("t6_cnt_run", 32'(count), 32'h000D);
    check("t6_addr_run", 32'(addr), 32'h00000004);
    rst = 1'b1;
    @(negedge clk);
    check("t6_rst_addr", 32'(addr), 32'h0);
    check("t6_rst_cnt", 32'(count), 32'h0);
    check("t6_rst_busy", 32'(busy), 32'h0);
    check("t6_rst_done", 32'(done), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("t6_post_cnt", 32'(count), 32'h0);
    check("t6_post_busy", 32'(busy), 32'h0);
    access = 1'b0;
    strobe(3'd5, 8'h00);
    check("t6_idle_start", 32'(done), 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
